// File: rtl/seeg_stim_sequencer.sv
// SEEG acquisition/stimulation sequencer: decodes command-register writes and
// schedules recording, impedance checks and finite/infinite stimulation trains.
module seeg_stim_sequencer #(
    parameter int ZCHECK_CYCLES = 1024,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [31:0]      cmd_word,
    input  logic [CNT_W-1:0] train_count,
    input  logic             stim_done,
    output logic             rec_en,
    output logic             stim_start,
    output logic             zcheck_en,
    output logic             zcheck_done,
    output logic [2:0]       state,
    output logic             cmd_err
);

    localparam int            ZW    = (ZCHECK_CYCLES > 1) ? $clog2(ZCHECK_CYCLES) : 1;
    localparam logic [ZW-1:0] ZLAST = ZW'(ZCHECK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ZCHECK    = 3'd1,
        S_RECORD    = 3'd2,
        S_STIM_FIN  = 3'd3,
        S_STIM_INF  = 3'd4,
        S_STIM_STOP = 3'd5
    } state_e;

    state_e           state_q, state_d, mid_state;
    logic [CNT_W-1:0] train_cnt_q, train_cnt_d;
    logic [ZW-1:0]    zcnt_q, zcnt_d;
    logic             stop_pend_q, stop_pend_d;
    logic             rec_en_q, rec_en_d;
    logic             stim_start_q, stim_start_d;
    logic             zcheck_en_q, zcheck_en_d;
    logic             zcheck_done_q, zcheck_done_d;
    logic             cmd_err_q, cmd_err_d;

    logic do_start_rec, do_stop_rec, do_start_z;
    logic do_start_fin, do_start_inf, do_stop_inf;
    logic any_cmd, accept, reject, launch;
    logic unused_cmd_bits;

    assign do_start_rec = cmd_valid & cmd_word[0];
    assign do_stop_rec  = cmd_valid & cmd_word[1];
    assign do_start_z   = cmd_valid & cmd_word[2];
    assign do_start_fin = cmd_valid & cmd_word[6];
    assign do_start_inf = cmd_valid & cmd_word[7];
    assign do_stop_inf  = cmd_valid & cmd_word[8];
    assign any_cmd      = do_start_rec | do_stop_rec | do_start_z |
                          do_start_fin | do_start_inf | do_stop_inf;

    assign unused_cmd_bits = ^{cmd_word[31:9], cmd_word[5:3]};

    always_comb begin
        mid_state   = state_q;
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        zcnt_d      = zcnt_q;
        stop_pend_d = stop_pend_q;
        launch      = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;

        // A completing train is resolved first; the command then sees the resulting state
        if (stim_done) begin
            case (state_q)
                S_STIM_FIN: begin
                    train_cnt_d = train_cnt_q - 1'b1;
                    if (train_cnt_d != '0) launch = 1'b1;
                    else                   mid_state = S_RECORD;
                end
                S_STIM_INF: launch = 1'b1;
                S_STIM_STOP: begin
                    mid_state   = stop_pend_q ? S_IDLE : S_RECORD;
                    stop_pend_d = 1'b0;
                end
                default: ;
            endcase
        end

        state_d = mid_state;
        case (mid_state)
            S_IDLE: begin
                if (do_start_z) begin
                    state_d = S_ZCHECK;
                    zcnt_d  = '0;
                    accept  = 1'b1;
                end else if (do_start_rec) begin
                    state_d = S_RECORD;
                    accept  = 1'b1;
                end else if (any_cmd) begin
                    reject = 1'b1;
                end
            end
            S_ZCHECK: begin
                if (do_stop_rec) begin
                    state_d = S_IDLE;
                    accept  = 1'b1;
                end else begin
                    reject = any_cmd;
                    if (zcnt_q == ZLAST) state_d = S_IDLE;
                    else                 zcnt_d  = zcnt_q + 1'b1;
                end
            end
            S_RECORD: begin
                if (do_stop_rec) begin
                    state_d = S_IDLE;
                    accept  = 1'b1;
                end else if (do_start_fin && train_count != '0) begin
                    state_d     = S_STIM_FIN;
                    train_cnt_d = train_count;
                    launch      = 1'b1;
                    accept      = 1'b1;
                end else if (do_start_inf) begin
                    state_d = S_STIM_INF;
                    launch  = 1'b1;
                    accept  = 1'b1;
                end else if (any_cmd) begin
                    reject = 1'b1;
                end
            end
            S_STIM_FIN, S_STIM_STOP: begin
                if (do_stop_rec) begin
                    state_d     = S_STIM_STOP;
                    stop_pend_d = 1'b1;
                    accept      = 1'b1;
                end else if (any_cmd) begin
                    reject = 1'b1;
                end
            end
            S_STIM_INF: begin
                if (do_stop_rec) begin
                    state_d     = S_STIM_STOP;
                    stop_pend_d = 1'b1;
                    accept      = 1'b1;
                end else if (do_stop_inf) begin
                    state_d = S_STIM_STOP;
                    accept  = 1'b1;
                end else if (any_cmd) begin
                    reject = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rec_en_d      = (state_d == S_RECORD) || (state_d == S_STIM_FIN) ||
                        (state_d == S_STIM_INF) || (state_d == S_STIM_STOP);
        stim_start_d  = launch;
        zcheck_en_d   = (state_d == S_ZCHECK);
        zcheck_done_d = (state_d == S_ZCHECK) && (zcnt_d == ZLAST);
        if (accept)      cmd_err_d = 1'b0;
        else if (reject) cmd_err_d = 1'b1;
        else             cmd_err_d = cmd_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            train_cnt_q   <= '0;
            zcnt_q        <= '0;
            stop_pend_q   <= 1'b0;
            rec_en_q      <= 1'b0;
            stim_start_q  <= 1'b0;
            zcheck_en_q   <= 1'b0;
            zcheck_done_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            train_cnt_q   <= train_cnt_d;
            zcnt_q        <= zcnt_d;
            stop_pend_q   <= stop_pend_d;
            rec_en_q      <= rec_en_d;
            stim_start_q  <= stim_start_d;
            zcheck_en_q   <= zcheck_en_d;
            zcheck_done_q <= zcheck_done_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign state       = state_q;
    assign rec_en      = rec_en_q;
    assign stim_start  = stim_start_q;
    assign zcheck_en   = zcheck_en_q;
    assign zcheck_done = zcheck_done_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_seeg_stim_sequencer.sv
// Bench for seeg_stim_sequencer: directed vector table, multi-cycle scenarios,
// and randomized commands checked against a behavioural model.
module tb_seeg_stim_sequencer;

    localparam int ZC = 16;
    localparam int CW = 16;
    localparam int PRIO [6] = '{1, 8, 6, 7, 2, 0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [31:0]   cmd_word = '0;
    logic [CW-1:0] train_count = '0;
    logic          stim_done = 1'b0;
    logic          rec_en, stim_start, zcheck_en, zcheck_done, cmd_err;
    logic [2:0]    state;

    always #5 clk = ~clk;

    seeg_stim_sequencer #(.ZCHECK_CYCLES(ZC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
        .train_count(train_count), .stim_done(stim_done), .rec_en(rec_en),
        .stim_start(stim_start), .zcheck_en(zcheck_en), .zcheck_done(zcheck_done),
        .state(state), .cmd_err(cmd_err)
    );

    int checks = 0;
    int failures = 0;
    int n_start, n_zen, n_zdone, zdone_at, n_rec_low;

    // Reference model: state number, trains left, zcheck cycles left incl. current
    int m_state, m_trains, m_zleft;
    bit m_pend, m_err, m_start;

    typedef struct {
        bit          cv;
        logic [31:0] cw;
        logic [15:0] tc;
        bit          sd;
        int          st;
        bit          start;
        bit          err;
        bit          rec;
        bit          zen;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit cv, input logic [31:0] cw, input logic [15:0] tc, input bit sd);
        cmd_valid   = cv;
        cmd_word    = cw;
        train_count = tc;
        stim_done   = sd;
        @(posedge clk);
        #1;
        if (stim_start) n_start++;
        if (zcheck_en) n_zen++;
        if (zcheck_done) begin
            n_zdone++;
            zdone_at = n_zen;
        end
        if (!rec_en) n_rec_low++;
        cmd_valid = 1'b0;
        stim_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 16'd0, 1'b0);
    endtask

    task automatic clear_counts();
        n_start = 0; n_zen = 0; n_zdone = 0; zdone_at = -1; n_rec_low = 0;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        stim_done = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_state = 0; m_trains = 0; m_zleft = 0;
        m_pend = 0; m_err = 0; m_start = 0;
    endtask

    function automatic bit is_legal(input int s, input int b, input int tc);
        case (s)
            0:       return (b == 2) || (b == 0);
            1:       return (b == 1);
            2:       return (b == 1) || (b == 7) || ((b == 6) && (tc != 0));
            3, 5:    return (b == 1);
            4:       return (b == 1) || (b == 8);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step(input bit cv, input logic [31:0] cw, input int tc, input bit sd);
        int s;
        int chosen;
        bit any;
        s = m_state;
        m_start = 0;
        if (sd) begin
            if (s == 3) begin
                m_trains--;
                if (m_trains > 0) m_start = 1;
                else s = 2;
            end else if (s == 4) begin
                m_start = 1;
            end else if (s == 5) begin
                s = m_pend ? 0 : 2;
                m_pend = 0;
            end
        end
        chosen = -1;
        any = 0;
        if (cv) begin
            for (int i = 0; i < 6; i++) begin
                if (cw[PRIO[i]]) begin
                    any = 1;
                    if (chosen < 0 && is_legal(s, PRIO[i], tc)) chosen = PRIO[i];
                end
            end
        end
        if (chosen >= 0) begin
            m_err = 0;
            case (chosen)
                1: begin
                    if (s >= 3) begin s = 5; m_pend = 1; end
                    else s = 0;
                end
                8: s = 5;
                6: begin s = 3; m_trains = tc; m_start = 1; end
                7: begin s = 4; m_start = 1; end
                2: begin s = 1; m_zleft = ZC; end
                default: s = 2;
            endcase
        end else begin
            if (any) m_err = 1;
            if (s == 1) begin
                m_zleft--;
                if (m_zleft == 0) s = 0;
            end
        end
        m_state = s;
    endtask

    function automatic logic [31:0] rand_word();
        int bits [6] = '{0, 1, 2, 6, 7, 8};
        int pick;
        logic [31:0] w;
        w = '0;
        pick = int'($urandom_range(0, 13));
        if (pick < 6) w[bits[pick]] = 1'b1;
        else if (pick < 8) begin
            w[bits[$urandom_range(0, 5)]] = 1'b1;
            w[bits[$urandom_range(0, 5)]] = 1'b1;
        end
        else if (pick == 9)  w[$urandom_range(9, 31)] = 1'b1;
        else if (pick == 10) w = $urandom;
        else if (pick == 11) w[0] = 1'b1;
        else if (pick == 12) w[7] = 1'b1;
        else if (pick == 13) w[6] = 1'b1;
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        clear_counts();

        // Reset state, sampled while rst is still held
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_rec_en", rec_en, 0);
        checkOutput("reset_stim_start", stim_start, 0);
        checkOutput("reset_zcheck_en", zcheck_en, 0);
        checkOutput("reset_zcheck_done", zcheck_done, 0);
        checkOutput("reset_cmd_err", cmd_err, 0);
        do_reset();

        // Finite run of 3 trains, stim_done every 100 cycles
        applyStimulus(1'b1, 32'h001, 16'd0, 1'b0);
        clear_counts();
        applyStimulus(1'b1, 32'h040, 16'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(99);
            applyStimulus(1'b0, 32'h0, 16'd0, 1'b1);
        end
        idle(5);
        checkOutput("fin3_starts", n_start, 3);
        checkOutput("fin3_rec_low_cycles", n_rec_low, 0);
        checkOutput("fin3_end_state", state, 2);

        // Infinite run: 5 trains, stop, final train completes
        clear_counts();
        applyStimulus(1'b1, 32'h080, 16'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle(19);
            applyStimulus(1'b0, 32'h0, 16'd0, 1'b1);
        end
        idle(3);
        applyStimulus(1'b1, 32'h100, 16'd0, 1'b0);
        checkOutput("inf_stop_state", state, 5);
        idle(10);
        applyStimulus(1'b0, 32'h0, 16'd0, 1'b1);
        idle(2);
        checkOutput("inf_starts", n_start, 6);
        checkOutput("inf_end_state", state, 2);

        // stop_record during infinite stimulation
        applyStimulus(1'b1, 32'h080, 16'd0, 1'b0);
        idle(10);
        clear_counts();
        applyStimulus(1'b1, 32'h002, 16'd0, 1'b0);
        checkOutput("stoprec_state", state, 5);
        idle(20);
        applyStimulus(1'b0, 32'h0, 16'd0, 1'b1);
        checkOutput("stoprec_end_state", state, 0);
        checkOutput("stoprec_end_rec_en", rec_en, 0);
        checkOutput("stoprec_no_start", n_start, 0);

        // Impedance check of ZC cycles
        do_reset();
        clear_counts();
        applyStimulus(1'b1, 32'h004, 16'd0, 1'b0);
        idle(ZC + 4);
        checkOutput("zcheck_en_cycles", n_zen, ZC);
        checkOutput("zcheck_done_pulses", n_zdone, 1);
        checkOutput("zcheck_done_position", zdone_at, ZC);
        checkOutput("zcheck_end_state", state, 0);

        // Asynchronous reset in the middle of a 4-train finite run
        applyStimulus(1'b1, 32'h001, 16'd0, 1'b0);
        applyStimulus(1'b1, 32'h040, 16'd4, 1'b0);
        idle(10);
        applyStimulus(1'b0, 32'h0, 16'd0, 1'b1);
        idle(5);
        checkOutput("midtrain_state", state, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_state", state, 0);
        checkOutput("async_rst_rec_en", rec_en, 0);
        checkOutput("async_rst_stim_start", stim_start, 0);
        checkOutput("async_rst_zcheck_en", zcheck_en, 0);
        checkOutput("async_rst_cmd_err", cmd_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_counts();
        for (int k = 0; k < 3; k++) begin
            idle(10);
            applyStimulus(1'b0, 32'h0, 16'd0, 1'b1);
        end
        checkOutput("post_rst_starts", n_start, 0);
        checkOutput("post_rst_state", state, 0);

        // Directed single-cycle vectors from IDLE with cmd_err clear
        vecs.push_back('{1, 32'h040, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 32'h000, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{1, 32'h001, 0, 0, 2, 0, 0, 1, 0});
        vecs.push_back('{1, 32'h040, 0, 0, 2, 0, 1, 1, 0});
        vecs.push_back('{1, 32'h000, 0, 0, 2, 0, 1, 1, 0});
        vecs.push_back('{1, 32'h040, 2, 0, 3, 1, 0, 1, 0});
        vecs.push_back('{0, 32'h000, 0, 0, 3, 0, 0, 1, 0});
        vecs.push_back('{0, 32'h000, 0, 1, 3, 1, 0, 1, 0});
        vecs.push_back('{0, 32'h000, 0, 1, 2, 0, 0, 1, 0});
        vecs.push_back('{1, 32'h080, 0, 0, 4, 1, 0, 1, 0});
        vecs.push_back('{1, 32'h001, 0, 0, 4, 0, 1, 1, 0});
        vecs.push_back('{0, 32'h000, 0, 1, 4, 1, 1, 1, 0});
        vecs.push_back('{1, 32'h102, 0, 0, 5, 0, 0, 1, 0});
        vecs.push_back('{0, 32'h000, 0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h005, 0, 0, 1, 0, 0, 0, 1});
        vecs.push_back('{1, 32'h001, 0, 0, 1, 0, 1, 0, 1});
        vecs.push_back('{1, 32'h002, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 32'h000, 0, 1, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h200, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 32'h001, 0, 0, 2, 0, 0, 1, 0});
        vecs.push_back('{1, 32'h040, 1, 0, 3, 1, 0, 1, 0});
        vecs.push_back('{1, 32'h080, 0, 1, 4, 1, 0, 1, 0});
        vecs.push_back('{1, 32'h100, 0, 0, 5, 0, 0, 1, 0});
        vecs.push_back('{0, 32'h000, 0, 1, 2, 0, 0, 1, 0});
        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].cv, vecs[i].cw, vecs[i].tc, vecs[i].sd);
            checkOutput($sformatf("vec%0d_state", i), state, vecs[i].st);
            checkOutput($sformatf("vec%0d_stim_start", i), stim_start, vecs[i].start);
            checkOutput($sformatf("vec%0d_cmd_err", i), cmd_err, vecs[i].err);
            checkOutput($sformatf("vec%0d_rec_en", i), rec_en, vecs[i].rec);
            checkOutput($sformatf("vec%0d_zcheck_en", i), zcheck_en, vecs[i].zen);
        end

        // Randomized commands and train completions against the model
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            bit          cv, sd;
            logic [31:0] cw;
            logic [15:0] tc;
            cv = ($urandom_range(0, 99) < 12);
            cw = rand_word();
            tc = 16'($urandom_range(0, 3));
            sd = ($urandom_range(0, 7) == 0);
            applyStimulus(cv, cw, tc, sd);
            model_step(cv, cw, int'(tc), sd);
            checkOutput("rand_state", state, m_state);
            checkOutput("rand_stim_start", stim_start, m_start);
            checkOutput("rand_cmd_err", cmd_err, m_err);
            checkOutput("rand_rec_en", rec_en, (m_state >= 2 && m_state <= 5) ? 1 : 0);
            checkOutput("rand_zcheck_en", zcheck_en, (m_state == 1) ? 1 : 0);
            checkOutput("rand_zcheck_done", zcheck_done, (m_state == 1 && m_zleft == 1) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seeg_stim_sequencer.md
SEEG_STIM_SEQUENCER -- requirements
Module: seeg_stim_sequencer

Interface
REQ-001 Parameter ZCHECK_CYCLES, default 1024, number of clk cycles zcheck_en is held high per impedance check.
REQ-002 Parameter CNT_W, default 16, width of the finite-train count and the internal train counter.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  one-cycle pulse when command register 0 is written over AXI-Lite.
REQ-006 cmd_word  input  32  written command value; bit0 start_record, bit1 stop_record, bit2 start_zcheck, bit6 start_stim_finite, bit7 start_stim_infinite, bit8 stop_stim_infinite; other bits ignored.
REQ-007 train_count  input  CNT_W  number of stim trains for a finite run, sampled when start_stim_finite is accepted.
REQ-008 stim_done  input  1  one-cycle pulse from the stim engine when a train completes.
REQ-009 rec_en  output  1  enables the recording stream datapath.
REQ-010 stim_start  output  1  one-cycle pulse that launches one stim train.
REQ-011 zcheck_en  output  1  enables the impedance-check path.
REQ-012 zcheck_done  output  1  one-cycle pulse at the end of an impedance check.
REQ-013 state  output  3  current state encoding, readable through the status register.
REQ-014 cmd_err  output  1  sticky flag for a rejected command; cleared by the next accepted command.

Function
REQ-015 The block SHALL act only on cycles where cmd_valid=1; a write of 0 (cmd_valid=1, cmd_word=0) SHALL be a no-op that leaves cmd_err unchanged.
REQ-016 States SHALL be IDLE=0, ZCHECK=1, RECORD=2, STIM_FIN=3, STIM_INF=4, STIM_STOP=5; codes 6 and 7 SHALL return to IDLE on the next cycle.
REQ-017 When several command bits are set in one write, only the highest-priority legal bit SHALL be acted on, in this order: stop_record, stop_stim_infinite, start_stim_finite, start_stim_infinite, start_zcheck, start_record.
REQ-018 IDLE: start_record SHALL go to RECORD, and start_zcheck SHALL go to ZCHECK with the zcheck counter cleared; any other bit SHALL set cmd_err.
REQ-019 ZCHECK: zcheck_en=1 for exactly ZCHECK_CYCLES cycles; zcheck_done SHALL pulse on the last cycle, then the block SHALL return to IDLE; commands here SHALL set cmd_err, except stop_record, which aborts to IDLE without a zcheck_done pulse.
REQ-020 RECORD: start_stim_finite with train_count>0 SHALL load the counter and go to STIM_FIN; train_count=0 SHALL set cmd_err and stay in RECORD.
REQ-021 RECORD: start_stim_infinite SHALL go to STIM_INF, stop_record SHALL go to IDLE, and any other bit SHALL set cmd_err.
REQ-022 stim_start SHALL pulse in the first cycle of STIM_FIN or STIM_INF, registered, which is 1 cycle after the accepted cmd_valid.
REQ-023 STIM_FIN: on each stim_done the counter SHALL decrement; if the result is nonzero, stim_start SHALL pulse the next cycle; if it is zero, the block SHALL return to RECORD the next cycle.
REQ-024 STIM_INF: each stim_done SHALL cause a stim_start pulse the next cycle; stop_stim_infinite SHALL go to STIM_STOP.
REQ-025 STIM_STOP: no further stim_start pulses; on stim_done the block SHALL go to RECORD, or to IDLE if a stop_record is pending.
REQ-026 stop_record in STIM_FIN, STIM_INF or STIM_STOP SHALL set the pending flag and go to or stay in STIM_STOP; a train in flight is never truncated.
REQ-027 In stim states, start_* commands SHALL set cmd_err with no state change.
REQ-028 If stim_done and cmd_valid occur in the same cycle, stim_done SHALL be applied first and the command evaluated against the resulting state.
REQ-029 stim_done outside STIM_FIN, STIM_INF and STIM_STOP SHALL be ignored.
REQ-030 rec_en SHALL be 1 in RECORD, STIM_FIN, STIM_INF and STIM_STOP, and 0 otherwise.
REQ-031 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-032 rst=1 SHALL immediately force state=IDLE and all outputs to 0: rec_en, stim_start, zcheck_en, zcheck_done, cmd_err.
REQ-033 rst=1 SHALL also clear the train counter, the zcheck counter and the pending stop_record flag.
REQ-034 Reset asserted mid-train SHALL abandon the train; no stim_start SHALL be issued after rst deasserts until a new command is accepted.

Verification
REQ-035 start_record then start_stim_finite with train_count=3 and stim_done every 100 cycles -> exactly 3 stim_start pulses, then state=2, rec_en held 1 throughout.
REQ-036 start_stim_infinite, 5 stim_done pulses, then stop_stim_infinite, then one stim_done -> 6 stim_start pulses total, then state=2.
REQ-037 start_zcheck from IDLE with ZCHECK_CYCLES=16 -> zcheck_en high for 16 cycles, zcheck_done on the 16th cycle, then state=0.
REQ-038 start_stim_finite in IDLE, and train_count=0 in RECORD -> cmd_err=1, state unchanged; a following write of 0 leaves cmd_err=1; the next accepted command clears it.
REQ-039 stop_record during STIM_INF -> state=5, no new stim_start, then state=0 and rec_en=0 the cycle after the next stim_done.
REQ-040 rst pulsed during STIM_FIN with train_count=4 -> all outputs 0 immediately, state=0, and no stim_start on later stim_done pulses.
